// File: rtl/as_pack.sv
// rtl/as_pack.sv - shared opcodes, status bit indices and TAP state encoding
package as_pack;

   typedef enum logic [3:0] {
      TAP_TLR,
      TAP_RTI,
      TAP_SEL_DR,
      TAP_CAP_DR,
      TAP_SHIFT_DR,
      TAP_EXIT1_DR,
      TAP_PAUSE_DR,
      TAP_EXIT2_DR,
      TAP_UPD_DR,
      TAP_SEL_IR,
      TAP_CAP_IR,
      TAP_SHIFT_IR,
      TAP_EXIT1_IR,
      TAP_PAUSE_IR,
      TAP_EXIT2_IR,
      TAP_UPD_IR
   } tap_state_t;

   localparam logic [7:0] IR_WRITE  = 8'h80;
   localparam logic [7:0] IR_BURST  = 8'h81;
   localparam logic [7:0] IR_READ   = 8'h82;
   localparam logic [7:0] IR_CHSEL  = 8'h83;
   localparam logic [7:0] IR_RUN    = 8'h84;
   localparam logic [7:0] IR_HALT   = 8'h85;
   localparam logic [7:0] IR_BYPASS = 8'hFF;

   localparam int ST_HOLD    = 0;
   localparam int ST_PENDING = 1;
   localparam int ST_OVERRUN = 2;
   localparam int ST_WRAP    = 3;

endpackage

// File: rtl/as_jtag_tap.sv
// rtl/as_jtag_tap.sv - IEEE 1149.1 TAP controller clocked by detected TCK rises
module as_jtag_tap
   import as_pack::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       trst_n,
   input  logic       tck_rise,
   input  logic       tms,
   output tap_state_t state,
   output logic       tlr,
   output logic       capture_dr,
   output logic       shift_dr,
   output logic       update_dr,
   output logic       capture_ir,
   output logic       shift_ir,
   output logic       update_ir
);

   tap_state_t next_state;

   // State register: advances only on a TCK rise; either reset forces Test-Logic-Reset
   always_ff @(posedge clk) begin
      if (!rst_n || !trst_n) state <= TAP_TLR;
      else if (tck_rise)     state <= next_state;
   end

   // Next-state table plus one-clk strobes; capture/shift act on the rise leaving the state,
   // update acts on the rise entering the state
   always_comb begin
      next_state = state;
      case (state)
         TAP_TLR:      next_state = tms ? TAP_TLR      : TAP_RTI;
         TAP_RTI:      next_state = tms ? TAP_SEL_DR   : TAP_RTI;
         TAP_SEL_DR:   next_state = tms ? TAP_SEL_IR   : TAP_CAP_DR;
         TAP_CAP_DR:   next_state = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
         TAP_SHIFT_DR: next_state = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
         TAP_EXIT1_DR: next_state = tms ? TAP_UPD_DR   : TAP_PAUSE_DR;
         TAP_PAUSE_DR: next_state = tms ? TAP_EXIT2_DR : TAP_PAUSE_DR;
         TAP_EXIT2_DR: next_state = tms ? TAP_UPD_DR   : TAP_SHIFT_DR;
         TAP_UPD_DR:   next_state = tms ? TAP_SEL_DR   : TAP_RTI;
         TAP_SEL_IR:   next_state = tms ? TAP_TLR      : TAP_CAP_IR;
         TAP_CAP_IR:   next_state = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
         TAP_SHIFT_IR: next_state = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
         TAP_EXIT1_IR: next_state = tms ? TAP_UPD_IR   : TAP_PAUSE_IR;
         TAP_PAUSE_IR: next_state = tms ? TAP_EXIT2_IR : TAP_PAUSE_IR;
         TAP_EXIT2_IR: next_state = tms ? TAP_UPD_IR   : TAP_SHIFT_IR;
         TAP_UPD_IR:   next_state = tms ? TAP_SEL_DR   : TAP_RTI;
         default:      next_state = TAP_TLR;
      endcase
      tlr        = (state == TAP_TLR);
      capture_dr = tck_rise && (state == TAP_CAP_DR);
      shift_dr   = tck_rise && (state == TAP_SHIFT_DR);
      update_dr  = tck_rise && (next_state == TAP_UPD_DR);
      capture_ir = tck_rise && (state == TAP_CAP_IR);
      shift_ir   = tck_rise && (state == TAP_SHIFT_IR);
      update_ir  = tck_rise && (next_state == TAP_UPD_IR);
   end

endmodule

// File: rtl/as_jtag_memload.sv
// rtl/as_jtag_memload.sv - JTAG-driven memory loader with burst writes, reads and core hold
module as_jtag_memload
   import as_pack::*;
#(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32,
   parameter int NCH    = 2
)(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              tck_i,
   input  logic              tms_i,
   input  logic              tdi_i,
   input  logic              trst_i,
   output logic              tdo_o,
   output logic [NCH-1:0]    mem_sel_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   output logic              mem_we_o,
   output logic              mem_re_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   input  logic              mem_ack_i,
   output logic              hold_o,
   output logic [3:0]        status_o
);

   localparam int DR_W = ADDR_W + DATA_W + 1;
   localparam int RD_W = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;
   localparam int STEP = DATA_W / 8;

   logic [3:0] sync1, sync2;
   logic       tck_q, tck_rise, tck_fall, tms_s, tdi_s, trst_s;

   tap_state_t tap_state;
   logic tlr, capture_dr, shift_dr, update_dr, capture_ir, shift_ir, update_ir;

   logic [7:0]        ir, ir_sr;
   logic [DR_W-1:0]   dr, dr_shifted, dr_cap;
   int                dr_len;
   logic [ADDR_W-1:0] base;
   logic [ADDR_W:0]   burst_sum;
   logic [2:0]        chan;
   logic [NCH-1:0]    chan_onehot;
   logic [DATA_W-1:0] rdata_q;
   logic              wrap, overrun, pending, is_req;

   // Two-flop synchronisers for the JTAG pins plus a delayed TCK for edge detection
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         sync1 <= '0;
         sync2 <= '0;
         tck_q <= 1'b0;
      end else begin
         sync1 <= {trst_i, tdi_i, tms_i, tck_i};
         sync2 <= sync1;
         tck_q <= sync2[0];
      end
   end

   assign tck_rise = sync2[0] & ~tck_q;
   assign tck_fall = ~sync2[0] & tck_q;
   assign tms_s    = sync2[1];
   assign tdi_s    = sync2[2];
   assign trst_s   = sync2[3];

   as_jtag_tap u_tap (
      .clk        (clk_i),
      .rst_n      (rst_i),
      .trst_n     (trst_s),
      .tck_rise   (tck_rise),
      .tms        (tms_s),
      .state      (tap_state),
      .tlr        (tlr),
      .capture_dr (capture_dr),
      .shift_dr   (shift_dr),
      .update_dr  (update_dr),
      .capture_ir (capture_ir),
      .shift_ir   (shift_ir),
      .update_ir  (update_ir)
   );

   assign pending     = mem_we_o | mem_re_o;
   assign burst_sum   = {1'b0, base} + (ADDR_W+1)'(STEP);
   assign chan_onehot = NCH'(1) << chan;

   // Sticky and live flags packed into the status word
   always_comb begin
      status_o             = '0;
      status_o[ST_HOLD]    = hold_o;
      status_o[ST_PENDING] = pending;
      status_o[ST_OVERRUN] = overrun;
      status_o[ST_WRAP]    = wrap;
   end

   // Selected DR length, capture value and request decode for the current instruction
   always_comb begin
      dr_len = 1;
      dr_cap = '0;
      is_req = 1'b0;
      case (ir)
         IR_WRITE: begin dr_len = DR_W;     dr_cap[3:0] = status_o; is_req = dr[0]; end
         IR_BURST: begin dr_len = DATA_W+1; dr_cap[3:0] = status_o; is_req = dr[0]; end
         IR_READ:  begin dr_len = RD_W;     dr_cap[DATA_W-1:0] = rdata_q; is_req = 1'b1; end
         IR_CHSEL: begin dr_len = 3;        dr_cap[2:0] = chan; end
         default:  dr_len = 1;
      endcase
   end

   // Variable-length LSB-first shift: TDI enters at the top bit of the active register
   always_comb begin
      dr_shifted = '0;
      for (int i = 0; i < DR_W-1; i++) begin
         if (i == dr_len - 1)     dr_shifted[i] = tdi_s;
         else if (i < dr_len - 1) dr_shifted[i] = dr[i+1];
      end
      dr_shifted[DR_W-1] = (dr_len == DR_W) ? tdi_s : 1'b0;
   end

   // IR/DR shift registers, hold control and falling-edge TDO
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         ir     <= IR_BYPASS;
         ir_sr  <= '0;
         dr     <= '0;
         tdo_o  <= 1'b0;
         hold_o <= 1'b1;
      end else begin
         if (tlr) ir <= IR_BYPASS;
         if (capture_ir)    ir_sr <= 8'h01;
         else if (shift_ir) ir_sr <= {ir_sr[6:0], tdi_s};
         if (update_ir) begin
            ir <= ir_sr;
            if (ir_sr == IR_RUN)       hold_o <= 1'b0;
            else if (ir_sr == IR_HALT) hold_o <= 1'b1;
         end
         if (capture_dr)    dr <= dr_cap;
         else if (shift_dr) dr <= dr_shifted;
         if (tck_fall) begin
            if (tap_state == TAP_SHIFT_DR)      tdo_o <= dr[0];
            else if (tap_state == TAP_SHIFT_IR) tdo_o <= ir_sr[7];
            else                                tdo_o <= 1'b0;
         end
      end
   end

   // Memory request issue/complete, burst base tracking, channel select and sticky flags
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         mem_we_o    <= 1'b0;
         mem_re_o    <= 1'b0;
         mem_sel_o   <= '0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         rdata_q     <= '0;
         base        <= '0;
         chan        <= '0;
         wrap        <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         if (mem_ack_i && pending) begin
            mem_we_o  <= 1'b0;
            mem_re_o  <= 1'b0;
            mem_sel_o <= '0;
            if (mem_re_o) rdata_q <= mem_rdata_i;
         end
         if (update_dr) begin
            if (is_req && pending) begin
               overrun <= 1'b1;
            end else begin
               case (ir)
                  IR_WRITE: if (dr[0]) begin
                     mem_addr_o  <= dr[DATA_W+ADDR_W:DATA_W+1];
                     base        <= dr[DATA_W+ADDR_W:DATA_W+1];
                     mem_wdata_o <= dr[DATA_W:1];
                     mem_we_o    <= 1'b1;
                     mem_sel_o   <= chan_onehot;
                  end
                  IR_BURST: if (dr[0]) begin
                     mem_addr_o  <= burst_sum[ADDR_W-1:0];
                     base        <= burst_sum[ADDR_W-1:0];
                     mem_wdata_o <= dr[DATA_W:1];
                     mem_we_o    <= 1'b1;
                     mem_sel_o   <= chan_onehot;
                     if (burst_sum[ADDR_W]) wrap <= 1'b1;
                  end
                  IR_READ: begin
                     mem_addr_o <= dr[ADDR_W-1:0];
                     mem_re_o   <= 1'b1;
                     mem_sel_o  <= chan_onehot;
                  end
                  IR_CHSEL: if (int'(dr[2:0]) < NCH) chan <= dr[2:0];
                  default: ;
               endcase
            end
         end
         if (tlr) begin
            wrap    <= 1'b0;
            overrun <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_as_jtag_memload.sv
// tb/tb_as_jtag_memload.sv - directed self-checking bench for as_jtag_memload
module tb_as_jtag_memload;

   logic        clk_i = 1'b0;
   logic        rst_i, tck_i, tms_i, tdi_i, trst_i;
   logic        tdo_o;
   logic [1:0]  mem_sel_o;
   logic [11:0] mem_addr_o;
   logic [31:0] mem_wdata_o, mem_rdata_i;
   logic        mem_we_o, mem_re_o, mem_ack_i, hold_o;
   logic [3:0]  status_o;

   int checks = 0;
   int errors = 0;
   int busy_cycles = 0;

   as_jtag_memload #(.ADDR_W(12), .DATA_W(32), .NCH(2)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .tck_i       (tck_i),
      .tms_i       (tms_i),
      .tdi_i       (tdi_i),
      .trst_i      (trst_i),
      .tdo_o       (tdo_o),
      .mem_sel_o   (mem_sel_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_we_o    (mem_we_o),
      .mem_re_o    (mem_re_o),
      .mem_rdata_i (mem_rdata_i),
      .mem_ack_i   (mem_ack_i),
      .hold_o      (hold_o),
      .status_o    (status_o)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) if (mem_we_o || mem_re_o) busy_cycles <= busy_cycles + 1;

   task automatic tck_step(input logic tms_v, input logic tdi_v, output logic tdo_v);
      tms_i = tms_v;
      tdi_i = tdi_v;
      repeat (4) @(negedge clk_i);
      tdo_v = tdo_o;
      tck_i = 1'b1;
      repeat (4) @(negedge clk_i);
      tck_i = 1'b0;
   endtask

   task automatic tap_reset();
      logic b;
      repeat (5) tck_step(1'b1, 1'b0, b);
   endtask

   task automatic scan_ir(input logic [7:0] v);
      logic b;
      tck_step(1'b1, 1'b0, b);
      tck_step(1'b1, 1'b0, b);
      tck_step(1'b0, 1'b0, b);
      tck_step(1'b0, 1'b0, b);
      for (int i = 0; i < 8; i++) tck_step(logic'(i == 7), v[7-i], b);
      tck_step(1'b1, 1'b0, b);
      tck_step(1'b0, 1'b0, b);
   endtask

   task automatic scan_dr(input logic [63:0] v, input int n, output logic [63:0] out);
      logic b;
      out = '0;
      tck_step(1'b1, 1'b0, b);
      tck_step(1'b0, 1'b0, b);
      tck_step(1'b0, 1'b0, b);
      for (int i = 0; i < n; i++) begin
         tck_step(logic'(i == n-1), v[i], b);
         out[i] = b;
      end
      tck_step(1'b1, 1'b0, b);
      tck_step(1'b0, 1'b0, b);
   endtask

   task automatic pulse_ack();
      mem_ack_i = 1'b1;
      @(negedge clk_i);
      mem_ack_i = 1'b0;
   endtask

   task automatic test_reset();
      logic b;
      logic [63:0] out;
      rst_i = 1'b0; tck_i = 1'b0; tms_i = 1'b1; tdi_i = 1'b0; trst_i = 1'b1;
      mem_ack_i = 1'b0; mem_rdata_i = '0;
      repeat (3) @(negedge clk_i);
      rst_i = 1'b1;
      @(negedge clk_i);
      checks++;
      if (hold_o !== 1'b1 || status_o !== 4'b0001 || tdo_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags hold=%b status=%b tdo=%b, need 1 0001 0", hold_o, status_o, tdo_o);
      end
      checks++;
      if (mem_we_o !== 1'b0 || mem_re_o !== 1'b0 || mem_sel_o !== 2'b00 || mem_addr_o !== 12'h0 || mem_wdata_o !== 32'h0) begin
         errors++;
         $display("FAIL reset_mem we=%b re=%b sel=%b addr=%h wdata=%h, need all 0", mem_we_o, mem_re_o, mem_sel_o, mem_addr_o, mem_wdata_o);
      end
      tap_reset();
      tck_step(1'b0, 1'b0, b);
      scan_dr(64'h1, 2, out);
      checks++;
      if (out[1:0] !== 2'b10) begin
         errors++;
         $display("FAIL reset_bypass got %b need 10", out[1:0]);
      end
      checks++;
      if (hold_o !== 1'b1 || status_o !== 4'b0001 || mem_we_o !== 1'b0 || mem_re_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_after_tlr hold=%b status=%b we=%b re=%b", hold_o, status_o, mem_we_o, mem_re_o);
      end
   endtask

   task automatic test_write();
      logic [63:0] out;
      scan_ir(8'h80);
      scan_dr({20'd0, 12'hFF0, 32'hAAAAAAAA, 1'b1}, 45, out);
      checks++;
      if (out[3:0] !== 4'b0001) begin
         errors++;
         $display("FAIL write_capture_status got %b need 0001", out[3:0]);
      end
      checks++;
      if (mem_we_o !== 1'b1 || mem_re_o !== 1'b0 || mem_addr_o !== 12'hFF0 || mem_wdata_o !== 32'hAAAAAAAA || mem_sel_o !== 2'b01) begin
         errors++;
         $display("FAIL write_req we=%b re=%b addr=%h wdata=%h sel=%b, need 1 0 ff0 aaaaaaaa 01", mem_we_o, mem_re_o, mem_addr_o, mem_wdata_o, mem_sel_o);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         checks++;
         if (mem_we_o !== 1'b1 || status_o[1] !== 1'b1) begin
            errors++;
            $display("FAIL write_hold cycle %0d we=%b pending=%b, need 1 1", i, mem_we_o, status_o[1]);
         end
      end
      pulse_ack();
      checks++;
      if (mem_we_o !== 1'b0 || mem_sel_o !== 2'b00 || status_o !== 4'b0001) begin
         errors++;
         $display("FAIL write_ack we=%b sel=%b status=%b, need 0 00 0001", mem_we_o, mem_sel_o, status_o);
      end
   endtask

   task automatic test_burst();
      logic [63:0] out;
      logic [11:0] exp_addr [4] = '{12'hFF4, 12'hFF8, 12'hFFC, 12'h000};
      scan_ir(8'h81);
      for (int i = 0; i < 4; i++) begin
         scan_dr({31'd0, 32'h55555555, 1'b1}, 33, out);
         checks++;
         if (mem_we_o !== 1'b1 || mem_addr_o !== exp_addr[i] || mem_wdata_o !== 32'h55555555 || status_o[3] !== logic'(i == 3)) begin
            errors++;
            $display("FAIL burst_%0d we=%b addr=%h wdata=%h wrap=%b, need 1 %h 55555555 %b", i, mem_we_o, mem_addr_o, mem_wdata_o, status_o[3], exp_addr[i], i == 3);
         end
         @(negedge clk_i);
         pulse_ack();
      end
      checks++;
      if (status_o !== 4'b1001) begin
         errors++;
         $display("FAIL burst_wrap_sticky status=%b need 1001", status_o);
      end
   endtask

   task automatic test_read();
      logic [63:0] out;
      scan_ir(8'h83);
      scan_dr(64'h1, 3, out);
      scan_ir(8'h82);
      scan_dr(64'hFF0, 32, out);
      checks++;
      if (mem_re_o !== 1'b1 || mem_we_o !== 1'b0 || mem_addr_o !== 12'hFF0 || mem_sel_o !== 2'b10) begin
         errors++;
         $display("FAIL read_req re=%b we=%b addr=%h sel=%b, need 1 0 ff0 10", mem_re_o, mem_we_o, mem_addr_o, mem_sel_o);
      end
      mem_rdata_i = 32'hAAAAAAAA;
      repeat (2) @(negedge clk_i);
      checks++;
      if (mem_re_o !== 1'b1) begin
         errors++;
         $display("FAIL read_hold re=%b need 1", mem_re_o);
      end
      pulse_ack();
      mem_rdata_i = 32'h0;
      checks++;
      if (mem_re_o !== 1'b0) begin
         errors++;
         $display("FAIL read_ack re=%b need 0", mem_re_o);
      end
      scan_dr(64'h0, 32, out);
      checks++;
      if (out[31:0] !== 32'hAAAAAAAA) begin
         errors++;
         $display("FAIL read_data got %h need aaaaaaaa", out[31:0]);
      end
      @(negedge clk_i);
      pulse_ack();
   endtask

   task automatic test_back_to_back();
      logic [63:0] out;
      int b0;
      scan_ir(8'h80);
      scan_dr({20'd0, 12'h100, 32'h11111111, 1'b1}, 45, out);
      checks++;
      if (mem_we_o !== 1'b1 || mem_addr_o !== 12'h100 || status_o[2] !== 1'b0) begin
         errors++;
         $display("FAIL b2b_first we=%b addr=%h overrun=%b, need 1 100 0", mem_we_o, mem_addr_o, status_o[2]);
      end
      scan_dr({20'd0, 12'h200, 32'h22222222, 1'b1}, 45, out);
      checks++;
      if (mem_we_o !== 1'b1 || mem_addr_o !== 12'h100 || mem_wdata_o !== 32'h11111111 || status_o[2] !== 1'b1) begin
         errors++;
         $display("FAIL b2b_overrun we=%b addr=%h wdata=%h overrun=%b, need 1 100 11111111 1", mem_we_o, mem_addr_o, mem_wdata_o, status_o[2]);
      end
      pulse_ack();
      b0 = busy_cycles;
      repeat (30) @(negedge clk_i);
      checks++;
      if (busy_cycles != b0 || mem_we_o !== 1'b0) begin
         errors++;
         $display("FAIL b2b_dropped busy cycles %0d we=%b, need 0 0", busy_cycles - b0, mem_we_o);
      end
      tap_reset();
      checks++;
      if (status_o !== 4'b0001) begin
         errors++;
         $display("FAIL tlr_clears_sticky status=%b need 0001", status_o);
      end
   endtask

   task automatic test_reset_pending();
      logic b;
      logic [63:0] out;
      tck_step(1'b0, 1'b0, b);
      scan_ir(8'h80);
      scan_dr({20'd0, 12'h010, 32'h12345678, 1'b1}, 45, out);
      checks++;
      if (mem_we_o !== 1'b1 || mem_addr_o !== 12'h010) begin
         errors++;
         $display("FAIL rstpend_req we=%b addr=%h, need 1 010", mem_we_o, mem_addr_o);
      end
      rst_i = 1'b0;
      @(negedge clk_i);
      checks++;
      if (mem_we_o !== 1'b0 || mem_sel_o !== 2'b00) begin
         errors++;
         $display("FAIL rstpend_drop we=%b sel=%b, need 0 00", mem_we_o, mem_sel_o);
      end
      repeat (2) @(negedge clk_i);
      rst_i = 1'b1;
      @(negedge clk_i);
   endtask

   task automatic test_run_hold();
      logic b;
      int b0;
      tck_step(1'b0, 1'b0, b);
      scan_ir(8'h84);
      checks++;
      if (hold_o !== 1'b0 || status_o[0] !== 1'b0) begin
         errors++;
         $display("FAIL run_hold hold=%b status0=%b, need 0 0", hold_o, status_o[0]);
      end
      scan_ir(8'h80);
      tck_step(1'b1, 1'b0, b);
      tck_step(1'b0, 1'b0, b);
      tck_step(1'b0, 1'b0, b);
      for (int i = 0; i < 20; i++) tck_step(1'b0, logic'(i % 2 == 0), b);
      b0 = busy_cycles;
      rst_i = 1'b0;
      repeat (3) @(negedge clk_i);
      rst_i = 1'b1;
      @(negedge clk_i);
      checks++;
      if (hold_o !== 1'b1 || status_o !== 4'b0001 || mem_we_o !== 1'b0 || mem_re_o !== 1'b0) begin
         errors++;
         $display("FAIL midshift_reset hold=%b status=%b we=%b re=%b, need 1 0001 0 0", hold_o, status_o, mem_we_o, mem_re_o);
      end
      tap_reset();
      tck_step(1'b0, 1'b0, b);
      checks++;
      if (busy_cycles != b0) begin
         errors++;
         $display("FAIL midshift_no_strobe busy cycles %0d need 0", busy_cycles - b0);
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_burst();
      test_read();
      test_back_to_back();
      test_reset_pending();
      test_run_hold();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
